// File: rtl/butterfly_unit_pipe.sv
// -----------------------------------------------------------------------------
// butterfly_unit_pipe
//
// Pipelined radix-2 DIT butterfly for the variable-length burst FFT:
//   o_do_1 = x1 + w*x2,  o_do_2 = x1 - w*x2   (complex, {real, imag} packing)
// Three register stages (conjugate/capture, multiply, add/scale), a single
// global enable so the whole pipe freezes under back-pressure, per-beat
// scale/inverse modes, and a sticky overflow flag.
//
// Ports:
//   i_clk, i_rst        rising-edge clock, synchronous active-high reset
//   i_valid / o_ready   input handshake (beat accepted when both high)
//   i_di_1, i_di_2      x1, x2: signed {real[2*DW-1:DW], imag[DW-1:0]}
//   i_w                 twiddle: signed Q0.(TW-1) {real, imag}
//   i_scale             1: halve with convergent rounding, 0: saturate
//   i_inv               1: use conj(w) (inverse transform)
//   o_valid / i_ready   output handshake (beat delivered when both high)
//   o_do_1, o_do_2      butterfly results, same packing as inputs
//   o_ovf, i_ovf_clr    sticky saturation flag and its clear
// -----------------------------------------------------------------------------
module butterfly_unit_pipe #(
    parameter int DW = 16,
    parameter int TW = 16
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [2*DW-1:0] i_di_1,
    input  logic [2*DW-1:0] i_di_2,
    input  logic [2*TW-1:0] i_w,
    input  logic            i_scale,
    input  logic            i_inv,
    output logic            o_valid,
    input  logic            i_ready,
    output logic [2*DW-1:0] o_do_1,
    output logic [2*DW-1:0] o_do_2,
    output logic            o_ovf,
    input  logic            i_ovf_clr
);

    // Width that holds a sum of two DW x TW products without wrapping.
    localparam int PW = DW + TW + 1;

    // Saturation bounds of a DW-bit signed value, sign-extended to PW bits.
    localparam logic signed [PW-1:0] MAXV = {{(PW-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [PW-1:0] MINV = {{(PW-DW+1){1'b1}}, {(DW-1){1'b0}}};
    // Half an LSB of the Q0.(TW-1) product scaling: 2^(TW-2).
    localparam logic signed [PW-1:0] RND  = {{(PW-TW+1){1'b0}}, 1'b1, {(TW-2){1'b0}}};

    // Clamp to DW bits; result is {saturated_flag, value}.
    function automatic logic [DW:0] sat_dw(input logic signed [PW-1:0] v);
        if (v > MAXV) begin
            sat_dw = {1'b1, MAXV[DW-1:0]};
        end else if (v < MINV) begin
            sat_dw = {1'b1, MINV[DW-1:0]};
        end else begin
            sat_dw = {1'b0, v[DW-1:0]};
        end
    endfunction

    // Final stage per component: halve with round-half-to-even (never
    // overflows), or saturate the DW+1 bit sum. Result is {flag, value}.
    function automatic logic [DW:0] finish_sum(input logic signed [DW:0] s,
                                               input logic scale);
        logic [DW-1:0] half;
        half = s[DW:1] + {{(DW-1){1'b0}}, s[0] & s[1]};
        if (scale) begin
            finish_sum = {1'b0, half};
        end else begin
            finish_sum = sat_dw({{(PW-DW-1){s[DW]}}, s});
        end
    endfunction

    // Global enable: advance whenever the output register is free or draining.
    logic en;
    assign en      = i_ready | ~o_valid;
    assign o_ready = en;

    // ---------------------------------------------------------------- stage 1
    logic signed [TW-1:0] w_re_in, w_im_in, w_im_conj;
    logic [2*TW-1:0]      w_1_d;

    assign w_re_in = i_w[2*TW-1:TW];
    assign w_im_in = i_w[TW-1:0];

    // NOTE: every combinational output gets its default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        w_im_conj = w_im_in;
        if (i_inv) begin
            // -(-1.0) is not representable; clamp to the largest positive.
            if (w_im_in == {1'b1, {(TW-1){1'b0}}}) begin
                w_im_conj = {1'b0, {(TW-1){1'b1}}};
            end else begin
                w_im_conj = -w_im_in;
            end
        end
    end

    assign w_1_d = {w_re_in, w_im_conj};

    logic            v1_q, scale_1_q;
    logic [2*DW-1:0] x1_1_q, x2_1_q;
    logic [2*TW-1:0] w_1_q;

    // ---------------------------------------------------------------- stage 2
    logic signed [PW-1:0] ar, ai, wr, wi, p_re, p_im, m_re_full, m_im_full;
    logic [DW:0]          sat_re, sat_im;
    logic [2*DW-1:0]      m_2_d;
    logic                 msat_2_d;

    assign ar = {{(PW-DW){x2_1_q[2*DW-1]}}, x2_1_q[2*DW-1:DW]};
    assign ai = {{(PW-DW){x2_1_q[DW-1]}},   x2_1_q[DW-1:0]};
    assign wr = {{(PW-TW){w_1_q[2*TW-1]}},  w_1_q[2*TW-1:TW]};
    assign wi = {{(PW-TW){w_1_q[TW-1]}},    w_1_q[TW-1:0]};

    assign p_re = ar * wr - ai * wi;
    assign p_im = ar * wi + ai * wr;

    // Round half-up, then drop the TW-1 fractional bits of the twiddle.
    assign m_re_full = (p_re + RND) >>> (TW - 1);
    assign m_im_full = (p_im + RND) >>> (TW - 1);

    assign sat_re   = sat_dw(m_re_full);
    assign sat_im   = sat_dw(m_im_full);
    assign m_2_d    = {sat_re[DW-1:0], sat_im[DW-1:0]};
    assign msat_2_d = sat_re[DW] | sat_im[DW];

    logic            v2_q, scale_2_q, msat_2_q;
    logic [2*DW-1:0] x1_2_q, m_2_q;

    // ---------------------------------------------------------------- stage 3
    logic signed [DW-1:0] x1r, x1i, mr, mi;
    logic signed [DW:0]   s1_re, s1_im, s2_re, s2_im;
    logic [DW:0]          f1_re, f1_im, f2_re, f2_im;
    logic [2*DW-1:0]      do1_d, do2_d;
    logic                 add_sat;

    assign x1r = x1_2_q[2*DW-1:DW];
    assign x1i = x1_2_q[DW-1:0];
    assign mr  = m_2_q[2*DW-1:DW];
    assign mi  = m_2_q[DW-1:0];

    assign s1_re = {x1r[DW-1], x1r} + {mr[DW-1], mr};
    assign s1_im = {x1i[DW-1], x1i} + {mi[DW-1], mi};
    assign s2_re = {x1r[DW-1], x1r} - {mr[DW-1], mr};
    assign s2_im = {x1i[DW-1], x1i} - {mi[DW-1], mi};

    assign f1_re = finish_sum(s1_re, scale_2_q);
    assign f1_im = finish_sum(s1_im, scale_2_q);
    assign f2_re = finish_sum(s2_re, scale_2_q);
    assign f2_im = finish_sum(s2_im, scale_2_q);

    assign do1_d   = {f1_re[DW-1:0], f1_im[DW-1:0]};
    assign do2_d   = {f2_re[DW-1:0], f2_im[DW-1:0]};
    assign add_sat = f1_re[DW] | f1_im[DW] | f2_re[DW] | f2_im[DW];

    logic            v3_q;
    logic [2*DW-1:0] do1_q, do2_q;

    // ------------------------------------------------------ pipeline registers
    // NOTE: state is updated with non-blocking assignments so each stage
    // captures the previous stage's value from before the edge.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            v1_q      <= 1'b0;
            scale_1_q <= 1'b0;
            x1_1_q    <= '0;
            x2_1_q    <= '0;
            w_1_q     <= '0;
            v2_q      <= 1'b0;
            scale_2_q <= 1'b0;
            msat_2_q  <= 1'b0;
            x1_2_q    <= '0;
            m_2_q     <= '0;
            v3_q      <= 1'b0;
            do1_q     <= '0;
            do2_q     <= '0;
        end else if (en) begin
            v1_q      <= i_valid;
            scale_1_q <= i_scale;
            x1_1_q    <= i_di_1;
            x2_1_q    <= i_di_2;
            w_1_q     <= w_1_d;
            v2_q      <= v1_q;
            scale_2_q <= scale_1_q;
            msat_2_q  <= msat_2_d;
            x1_2_q    <= x1_1_q;
            m_2_q     <= m_2_d;
            v3_q      <= v2_q;
            do1_q     <= do1_d;
            do2_q     <= do2_d;
        end
    end

    // ------------------------------------------------------- sticky overflow
    logic ovf_q, ovf_d;

    // Setting on a beat entering the output register beats a same-cycle clear.
    always_comb begin
        ovf_d = ovf_q;
        if (en & v2_q & (msat_2_q | add_sat)) begin
            ovf_d = 1'b1;
        end else if (i_ovf_clr) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign o_valid = v3_q;
    assign o_do_1  = do1_q;
    assign o_do_2  = do2_q;
    assign o_ovf   = ovf_q;

endmodule

// File: tb/tb_butterfly_unit_pipe.sv
// -----------------------------------------------------------------------------
// tb_butterfly_unit_pipe
//
// Directed vectors with known answers, a back-pressure stream, a mid-stream
// reset and a random soak. A negedge monitor compares every presented output
// beat and the sticky flag against an integer reference of the butterfly.
// -----------------------------------------------------------------------------
module tb_butterfly_unit_pipe;

    localparam int DW = 16;
    localparam int TW = 16;

    logic            clk = 1'b0;
    logic            i_rst, i_valid, i_scale, i_inv, i_ready, i_ovf_clr;
    logic            o_ready, o_valid, o_ovf;
    logic [2*DW-1:0] i_di_1, i_di_2, o_do_1, o_do_2;
    logic [2*TW-1:0] i_w;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    butterfly_unit_pipe #(.DW(DW), .TW(TW)) dut (
        .i_clk     (clk),
        .i_rst     (i_rst),
        .i_valid   (i_valid),
        .o_ready   (o_ready),
        .i_di_1    (i_di_1),
        .i_di_2    (i_di_2),
        .i_w       (i_w),
        .i_scale   (i_scale),
        .i_inv     (i_inv),
        .o_valid   (o_valid),
        .i_ready   (i_ready),
        .o_do_1    (o_do_1),
        .o_do_2    (o_do_2),
        .o_ovf     (o_ovf),
        .i_ovf_clr (i_ovf_clr)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ------------------------------------------------------- reference model
    typedef struct {
        logic [31:0] d1;
        logic [31:0] d2;
        bit          sat;
    } beat_t;

    function automatic longint fdiv(input longint n, input longint d);
        longint q;
        q = n / d;
        if ((n % d != 0) && ((n < 0) != (d < 0))) q--;
        return q;
    endfunction

    function automatic longint clamp16(input longint v, output bit hit);
        hit = 1'b0;
        if (v > 32767)  begin hit = 1'b1; return 32767;  end
        if (v < -32768) begin hit = 1'b1; return -32768; end
        return v;
    endfunction

    // v/2 rounded to nearest, ties to the even neighbour.
    function automatic longint half_even(input longint v);
        longint q;
        q = fdiv(v, 2);
        if ((v % 2 != 0) && (q % 2 != 0)) q++;
        return q;
    endfunction

    function automatic beat_t model(input logic [31:0] a, input logic [31:0] b,
                                    input logic [31:0] w, input logic s, input logic inv);
        beat_t  r;
        longint ar, ai, br, bi, wr, wi, pr, pi, mr, mi;
        longint t[4];
        longint o[4];
        bit     h1, h2, h;
        ar = $signed(a[31:16]);  ai = $signed(a[15:0]);
        br = $signed(b[31:16]);  bi = $signed(b[15:0]);
        wr = $signed(w[31:16]);  wi = $signed(w[15:0]);
        if (inv) wi = -wi;
        if (wi > 32767) wi = 32767;
        pr = br * wr - bi * wi;
        pi = br * wi + bi * wr;
        mr = clamp16(fdiv(pr + 16384, 32768), h1);
        mi = clamp16(fdiv(pi + 16384, 32768), h2);
        r.sat = h1 | h2;
        t[0] = ar + mr;  t[1] = ai + mi;
        t[2] = ar - mr;  t[3] = ai - mi;
        for (int k = 0; k < 4; k++) begin
            if (s) begin
                o[k] = half_even(t[k]);
            end else begin
                o[k] = clamp16(t[k], h);
                r.sat = r.sat | h;
            end
        end
        r.d1 = {16'(o[0]), 16'(o[1])};
        r.d2 = {16'(o[2]), 16'(o[3])};
        return r;
    endfunction

    // --------------------------------------------------------------- monitor
    beat_t exp_q[$];
    bit    ovf_model = 1'b0;
    bit    prev_en   = 1'b0;
    bit    prev_clr  = 1'b0;
    int    delivered = 0;

    always @(negedge clk) begin
        if (i_rst) begin
            exp_q.delete();
            ovf_model = 1'b0;
            prev_en   = 1'b0;
            prev_clr  = 1'b0;
        end else begin
            // An enabled edge that leaves o_valid high loaded the queue head.
            if (prev_en && o_valid && exp_q.size() > 0 && exp_q[0].sat) ovf_model = 1'b1;
            else if (prev_clr) ovf_model = 1'b0;
            check("mon_ovf", o_ovf, ovf_model);
            check("mon_ready", o_ready, i_ready || !o_valid);
            if (o_valid) begin
                check("mon_beat_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    check("mon_do_1", o_do_1, exp_q[0].d1);
                    check("mon_do_2", o_do_2, exp_q[0].d2);
                    if (i_ready) begin
                        void'(exp_q.pop_front());
                        delivered++;
                    end
                end
            end
            if (i_valid && o_ready) exp_q.push_back(model(i_di_1, i_di_2, i_w, i_scale, i_inv));
            prev_en  = o_ready;
            prev_clr = i_ovf_clr;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------- stimulus
    task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic [31:0] w,
                         input logic s, input logic inv);
        i_di_1  = a;
        i_di_2  = b;
        i_w     = w;
        i_scale = s;
        i_inv   = inv;
    endtask

    task automatic drain();
        i_valid = 1'b0;
        i_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
    endtask

    // Send one beat into an empty pipe and check its latency and result.
    task automatic send_check(input string tag, input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] w, input logic s, input logic inv,
                              input logic [31:0] e1, input logic [31:0] e2, input logic eovf);
        int lat;
        drive(a, b, w, s, inv);
        i_valid = 1'b1;
        i_ready = 1'b1;
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        lat = 1;
        while (!o_valid && lat < 10) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, "_latency"}, lat, 3);
        check({tag, "_do_1"}, o_do_1, e1);
        check({tag, "_do_2"}, o_do_2, e2);
        check({tag, "_ovf"}, o_ovf, eovf);
    endtask

    task automatic pulse_clr(input string tag);
        i_ovf_clr = 1'b1;
        @(posedge clk);
        #1;
        i_ovf_clr = 1'b0;
        check(tag, o_ovf, 0);
    endtask

    logic [31:0] ba[8], bb[8], bw[8];
    logic        bs[8], bi[8];
    int          sent, start, it, lat;
    bit          acc;

    initial begin
        i_rst = 1'b1; i_valid = 1'b0; i_ready = 1'b1; i_ovf_clr = 1'b0;
        drive('0, '0, '0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("reset_valid", o_valid, 0);
        check("reset_do_1", o_do_1, 0);
        check("reset_do_2", o_do_2, 0);
        check("reset_ovf", o_ovf, 0);
        i_rst = 1'b0;
        #1;
        check("reset_ready", o_ready, 1);

        // Basic latency and values.
        send_check("basic", 32'h4000_0000, 32'h4000_0000, 32'h7FFF_0000, 1'b1, 1'b0,
                   32'h4000_0000, 32'h0000_0000, 1'b0);
        drain();

        // (-1)*(-1) saturates, then convergent rounding on the halved sums.
        send_check("mult_sat", 32'h0000_0000, 32'h8000_0000, 32'h8000_0000, 1'b1, 1'b0,
                   32'h4000_0000, 32'hC000_0000, 1'b1);
        pulse_clr("mult_sat_clr");
        drain();

        // Sum overflow in saturating mode.
        send_check("add_sat", 32'h7000_0000, 32'h7000_0000, 32'h7FFF_0000, 1'b0, 1'b0,
                   32'h7FFF_0000, 32'h0001_0000, 1'b1);
        pulse_clr("add_sat_clr");
        drain();

        // Forward then inverse twiddle on back-to-back beats.
        drive(32'h0, 32'h0000_4000, 32'h0000_4000, 1'b0, 1'b0);
        i_valid = 1'b1;
        @(posedge clk);
        #1;
        drive(32'h0, 32'h0000_4000, 32'h0000_4000, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        lat = 0;
        while (!o_valid && lat < 10) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("fwd_valid", o_valid, 1);
        check("fwd_do_1", o_do_1, 32'hE000_0000);
        check("fwd_do_2", o_do_2, 32'h2000_0000);
        @(posedge clk);
        #1;
        check("inv_valid", o_valid, 1);
        check("inv_do_1", o_do_1, 32'h2000_0000);
        check("inv_do_2", o_do_2, 32'hE000_0000);
        drain();

        // Back-pressure: 8 beats, i_ready low for 4 cycles mid-stream.
        for (int k = 0; k < 8; k++) begin
            ba[k] = $urandom; bb[k] = $urandom; bw[k] = $urandom;
            bs[k] = 1'($urandom_range(0, 1)); bi[k] = 1'($urandom_range(0, 1));
        end
        sent = 0; start = delivered; it = 0;
        while ((delivered - start) < 8 && it < 100) begin
            i_ready = !(it >= 4 && it < 8);
            i_valid = (sent < 8);
            if (sent < 8) drive(ba[sent], bb[sent], bw[sent], bs[sent], bi[sent]);
            #1;
            acc = i_valid && o_ready;
            if (o_valid && !i_ready) check("bp_ready_low", o_ready, 0);
            @(posedge clk);
            #1;
            if (acc) sent++;
            it++;
        end
        i_valid = 1'b0;
        check("bp_all_delivered", delivered - start, 8);
        pulse_clr("bp_clr");
        drain();

        // Mid-stream reset with two beats in flight, after setting the flag.
        send_check("pre_rst", 32'h0000_0000, 32'h8000_0000, 32'h8000_0000, 1'b1, 1'b0,
                   32'h4000_0000, 32'hC000_0000, 1'b1);
        drain();
        drive(32'h1234_5678, 32'h7000_7000, 32'h7FFF_7FFF, 1'b0, 1'b0);
        i_valid = 1'b1;
        @(posedge clk);
        #1;
        drive(32'h0BAD_F00D, 32'h8000_8000, 32'h8000_8000, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        i_rst   = 1'b1;
        @(posedge clk);
        #1;
        i_rst = 1'b0;
        check("rst_mid_valid", o_valid, 0);
        check("rst_mid_do_1", o_do_1, 0);
        check("rst_mid_do_2", o_do_2, 0);
        check("rst_mid_ovf", o_ovf, 0);
        send_check("post_rst", 32'h4000_0000, 32'h4000_0000, 32'h7FFF_0000, 1'b1, 1'b0,
                   32'h4000_0000, 32'h0000_0000, 1'b0);
        drain();

        // Random soak with random handshakes and occasional flag clears.
        for (int n = 0; n < 200; n++) begin
            i_valid   = 1'($urandom_range(0, 1));
            i_ready   = ($urandom_range(0, 3) != 0);
            i_ovf_clr = ($urandom_range(0, 7) == 0);
            drive($urandom, $urandom,
                  ($urandom_range(0, 3) == 0) ? 32'h8000_8000 : $urandom,
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            @(posedge clk);
            #1;
        end
        i_ovf_clr = 1'b0;
        drain();
        check("soak_queue_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
